// File: rtl/reg_err_slv_log.sv
// Error-terminating register slave with programmable response latency, a saturating error counter
// and first-fault capture. Define REG_ERR_SLV_LOG_IRQ_EN to get a registered per-transfer irq pulse.

package reg_err_slv_log_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } rsp_t;

endpackage

module reg_err_slv_log #(
  parameter int unsigned   AW          = 32,
  parameter int unsigned   DW          = 32,
  parameter logic [DW-1:0] ERR_VAL     = '0,
  parameter int unsigned   RespLatency = 0,
  parameter int unsigned   CntWidth    = 8,
  parameter type           req_t       = reg_err_slv_log_pkg::req_t,
  parameter type           rsp_t       = reg_err_slv_log_pkg::rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  req_t                req_i,
  output rsp_t                rsp_o,
  input  logic                clr_i,
  output logic [CntWidth-1:0] err_cnt_o,
  output logic                logged_o,
  output logic [AW-1:0]       first_addr_o,
  output logic                first_write_o,
  output logic                irq_o
);

  localparam logic [CntWidth-1:0] CNT_MAX = '1;

  logic                ready_s;
  logic                xfer_s;
  logic [CntWidth-1:0] cnt_base_s;
  logic                logged_base_s;
  logic [CntWidth-1:0] err_cnt_r;
  logic                logged_r;
  logic [AW-1:0]       first_addr_r;
  logic                first_write_r;
  logic                unused_s;

  assign unused_s = ^{req_i.wdata, req_i.wstrb};

  if (RespLatency == 32'd0) begin : g_comb_ready
    assign ready_s = req_i.valid;
  end else begin : g_fsm
    localparam int unsigned LW = $clog2(RespLatency + 32'd1);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [LW-1:0] lat_r;
    logic [LW-1:0] lat_s;

    // Next-state and latency countdown; a dropped valid abandons the access silently
    always_comb begin
      state_s = state_r;
      lat_s   = lat_r;
      case (state_r)
        ST_IDLE: begin
          if (req_i.valid) begin
            lat_s   = LW'(RespLatency - 32'd1);
            state_s = (RespLatency == 32'd1) ? ST_RESP : ST_WAIT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          lat_s = lat_r - LW'(1);
          if (!req_i.valid) begin
            state_s = ST_IDLE;
          end else if (lat_r == LW'(1)) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_RESP: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
          lat_s   = '0;
        end
      endcase
    end

    // State and countdown registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_r <= ST_IDLE;
        lat_r   <= '0;
      end else begin
        state_r <= state_s;
        lat_r   <= lat_s;
      end
    end

    assign ready_s = (state_r == ST_RESP) && req_i.valid;
  end

  assign xfer_s = req_i.valid && ready_s;

  // Response is constant apart from the handshake
  always_comb begin
    rsp_o       = '0;
    rsp_o.rdata = ERR_VAL;
    rsp_o.error = 1'b1;
    rsp_o.ready = ready_s;
  end

  // A same-cycle clear is applied before the transfer is accounted
  always_comb begin
    cnt_base_s    = clr_i ? '0 : err_cnt_r;
    logged_base_s = logged_r && !clr_i;
  end

  // Saturating count of completed accesses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_r <= '0;
    end else if (xfer_s) begin
      err_cnt_r <= (cnt_base_s == CNT_MAX) ? CNT_MAX : cnt_base_s + CntWidth'(1);
    end else if (clr_i) begin
      err_cnt_r <= '0;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  // First-fault capture, sticky until cleared
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      logged_r      <= 1'b0;
      first_addr_r  <= '0;
      first_write_r <= 1'b0;
    end else if (xfer_s && !logged_base_s) begin
      logged_r      <= 1'b1;
      first_addr_r  <= AW'(req_i.addr);
      first_write_r <= req_i.write;
    end else if (clr_i) begin
      logged_r      <= 1'b0;
      first_addr_r  <= '0;
      first_write_r <= 1'b0;
    end else begin
      logged_r      <= logged_r;
      first_addr_r  <= first_addr_r;
      first_write_r <= first_write_r;
    end
  end

  assign err_cnt_o     = err_cnt_r;
  assign logged_o      = logged_r;
  assign first_addr_o  = first_addr_r;
  assign first_write_o = first_write_r;

`ifdef REG_ERR_SLV_LOG_IRQ_EN
  logic irq_r;

  // One pulse per completed transfer, independent of counter saturation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= xfer_s;
    end
  end

  assign irq_o = irq_r;
`else
  assign irq_o = 1'b0;
`endif

endmodule
